demux7_out: RTL and testbench

- Buffered 1-to-7 distributor. It is the opposite direction of the 7-input result selector.
- Accepts one 32-bit word plus a 3-bit destination code per handshake, queues it in a small FIFO, and presents it to exactly one of seven consumers using per-destination valid/ready.
- Sits between a single producer (execute/write-back result path) and up to seven sink registers or units that may stall independently.
- Destination code 3'b111 is invalid: the word is accepted and discarded, and a drop counter increments.

---
 rtl/demux7_out.sv | 207 ++++++++++++++++++++
 tb/tb_demux7_out.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux7_out.sv
// -----------------------------------------------------------------------------
// demux7_out
//
// Buffered 1-to-7 distributor. A single producer hands over one data word
// together with a 3-bit destination code. Each handshake is queued in a small
// FIFO. The head of the FIFO is then presented to exactly one of seven
// consumers through a one-hot OutValid and a shared DataOut bus. Destination
// code 7 is not a real consumer: such a word is accepted, discarded and counted
// in a saturating drop counter.
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst_n     in   asynchronous active-low reset
//   Order     in   destination code for DataIn (0..6 valid, 7 = drop)
//   DataIn    in   word to distribute
//   InValid   in   producer offers Order/DataIn this cycle
//   InReady   out  block accepts a word this cycle (registered)
//   DataOut   out  head-of-FIFO word, shared by all destinations (registered)
//   OutValid  out  one-hot destination of DataOut (registered)
//   OutReady  in   per-destination accept; only the selected bit matters
//   Count     out  FIFO occupancy
//   DropCnt   out  saturating count of discarded code-7 words
// -----------------------------------------------------------------------------
module demux7_out #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 Order,
    input  logic [WIDTH-1:0]           DataIn,
    input  logic                       InValid,
    output logic                       InReady,
    output logic [WIDTH-1:0]           DataOut,
    output logic [6:0]                 OutValid,
    input  logic [6:0]                 OutReady,
    output logic [$clog2(DEPTH):0]     Count,
    output logic [DROP_W-1:0]          DropCnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [2:0] DROP_CODE = 3'd7;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Decode a destination code into its OutValid pattern. Code 7 never
    // reaches the FIFO, so it maps to no destination at all.
    function automatic logic [6:0] orderToOneHot(input logic [2:0] ord);
        logic [6:0] hot;
        case (ord)
            3'd0:    hot = 7'b0000001;
            3'd1:    hot = 7'b0000010;
            3'd2:    hot = 7'b0000100;
            3'd3:    hot = 7'b0001000;
            3'd4:    hot = 7'b0010000;
            3'd5:    hot = 7'b0100000;
            3'd6:    hot = 7'b1000000;
            default: hot = 7'b0000000;
        endcase
        return hot;
    endfunction

    // FIFO storage; the destination code travels with its word.
    logic [WIDTH-1:0]  memData  [DEPTH];
    logic [2:0]        memOrder [DEPTH];

    // Registered state.
    logic [PTR_W-1:0]  wrPtrR;
    logic [PTR_W-1:0]  rdPtrR;
    logic [CNT_W-1:0]  countR;
    logic [WIDTH-1:0]  dataOutR;
    logic [6:0]        outValidR;
    logic              inReadyR;
    logic [DROP_W-1:0] dropCntR;

    // Next-state signals.
    logic              acceptS;
    logic              pushS;
    logic              dropS;
    logic              popS;
    logic [PTR_W-1:0]  wrPtrNextS;
    logic [PTR_W-1:0]  rdPtrNextS;
    logic [CNT_W-1:0]  afterPopS;
    logic [CNT_W-1:0]  countNextS;
    logic [2:0]        headOrderS;
    logic [WIDTH-1:0]  headDataS;
    logic [WIDTH-1:0]  dataOutNextS;
    logic [6:0]        outValidNextS;
    logic              inReadyNextS;
    logic [DROP_W-1:0] dropCntNextS;

    // Handshake decode. InReady is a register, so acceptance never depends
    // combinationally on OutReady; a pop cannot open room for a same-cycle push.
    always_comb begin
        acceptS = InValid & inReadyR;
        pushS   = acceptS & (Order != DROP_CODE);
        dropS   = acceptS & (Order == DROP_CODE);
        // outValidR is only nonzero while the FIFO holds a word, so masking
        // with it ignores ready bits of non-selected destinations.
        popS    = |(outValidR & OutReady);
    end

    // Pointer and occupancy update.
    always_comb begin
        wrPtrNextS = wrPtrR;
        rdPtrNextS = rdPtrR;
        afterPopS  = countR;
        countNextS = countR;

        if (pushS) begin
            wrPtrNextS = wrPtrR + PTR_W'(1);
        end else begin
            wrPtrNextS = wrPtrR;
        end

        if (popS) begin
            rdPtrNextS = rdPtrR + PTR_W'(1);
            afterPopS  = countR - CNT_W'(1);
        end else begin
            rdPtrNextS = rdPtrR;
            afterPopS  = countR;
        end

        if (pushS) begin
            countNextS = afterPopS + CNT_W'(1);
        end else begin
            countNextS = afterPopS;
        end
    end

    // Next head of the FIFO. When nothing older than the incoming word will
    // remain after this edge, the incoming word becomes the head directly;
    // otherwise the head is whatever sits at the advanced read pointer.
    always_comb begin
        headOrderS = memOrder[rdPtrNextS];
        headDataS  = memData[rdPtrNextS];
        if (pushS && (afterPopS == CNT_W'(0))) begin
            headOrderS = Order;
            headDataS  = DataIn;
        end else begin
            headOrderS = memOrder[rdPtrNextS];
            headDataS  = memData[rdPtrNextS];
        end
    end

    // Registered output image: DataOut keeps the last popped word while empty.
    always_comb begin
        outValidNextS = 7'b0000000;
        dataOutNextS  = dataOutR;
        if (countNextS != CNT_W'(0)) begin
            outValidNextS = orderToOneHot(headOrderS);
            dataOutNextS  = headDataS;
        end else begin
            outValidNextS = 7'b0000000;
            dataOutNextS  = dataOutR;
        end
        inReadyNextS = (countNextS != FULL_COUNT);
    end

    // Saturating drop counter: sticks at all-ones instead of wrapping.
    always_comb begin
        dropCntNextS = dropCntR;
        if (dropS && (dropCntR != {DROP_W{1'b1}})) begin
            dropCntNextS = dropCntR + DROP_W'(1);
        end else begin
            dropCntNextS = dropCntR;
        end
    end

    // FIFO storage write; contents need no reset because Count gates them.
    always_ff @(posedge clk) begin
        if (pushS) begin
            memData[wrPtrR]  <= DataIn;
            memOrder[wrPtrR] <= Order;
        end
    end

    // Control and output registers. InReady resets low and first rises on the
    // edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrR    <= '0;
            rdPtrR    <= '0;
            countR    <= '0;
            dataOutR  <= '0;
            outValidR <= 7'b0000000;
            inReadyR  <= 1'b0;
            dropCntR  <= '0;
        end else begin
            wrPtrR    <= wrPtrNextS;
            rdPtrR    <= rdPtrNextS;
            countR    <= countNextS;
            dataOutR  <= dataOutNextS;
            outValidR <= outValidNextS;
            inReadyR  <= inReadyNextS;
            dropCntR  <= dropCntNextS;
        end
    end

    assign InReady  = inReadyR;
    assign DataOut  = dataOutR;
    assign OutValid = outValidR;
    assign Count    = countR;
    assign DropCnt  = dropCntR;

endmodule

// File: tb/tb_demux7_out.sv
// -----------------------------------------------------------------------------
// tb_demux7_out
//
// Bench for demux7_out. A queue-based model tracks the words held inside the
// block, the last word delivered, the drop count and whether the block is
// ready. Each scenario task drives inputs, advances the clock through cycle(),
// and compares the DUT outputs with the model.
// -----------------------------------------------------------------------------
module tb_demux7_out;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 2;
    localparam int DROP_W = 8;

    logic              clk;
    logic              rst_n;
    logic [2:0]        Order;
    logic [WIDTH-1:0]  DataIn;
    logic              InValid;
    logic              InReady;
    logic [WIDTH-1:0]  DataOut;
    logic [6:0]        OutValid;
    logic [6:0]        OutReady;
    logic [1:0]        Count;
    logic [DROP_W-1:0] DropCnt;

    demux7_out #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Order    (Order),
        .DataIn   (DataIn),
        .InValid  (InValid),
        .InReady  (InReady),
        .DataOut  (DataOut),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Count    (Count),
        .DropCnt  (DropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  o;
        logic [31:0] d;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mLast;
    int          mDrop;
    logic        mReady;

    int tests;
    int fails;

    // Model view of what the outputs must be right now.
    function automatic logic [6:0] expValid();
        logic [6:0] v;
        v = 7'b0000000;
        if (mq.size() > 0) v[mq[0].o] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] expData();
        if (mq.size() > 0) return mq[0].d;
        return mLast;
    endfunction

    task automatic model_reset();
        mq.delete();
        mLast  = 32'h0;
        mDrop  = 0;
        mReady = 1'b0;
    endtask

    // One clock: decide accept/pop from the model, clock, update, settle.
    task automatic cycle();
        bit     acc;
        bit     pop;
        entry_t e;
        acc = InValid && mReady;
        pop = (mq.size() > 0) && OutReady[mq[0].o];
        e.o = Order;
        e.d = DataIn;
        @(posedge clk);
        if (rst_n) begin
            if (pop) begin
                mLast = mq[0].d;
                void'(mq.pop_front());
            end
            if (acc) begin
                if (e.o == 3'd7) begin
                    if (mDrop < 255) mDrop++;
                end else begin
                    mq.push_back(e);
                end
            end
            mReady = (mq.size() < DEPTH);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; InValid = 1'b0; Order = 3'd0; DataIn = 32'h0; OutReady = 7'h00;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (Count !== 2'd0)        begin fails++; $display("FAIL reset_count got=%0d exp=0", Count); end
        tests++; if (OutValid !== 7'h00)    begin fails++; $display("FAIL reset_valid got=%h exp=00", OutValid); end
        tests++; if (DataOut !== 32'h0)     begin fails++; $display("FAIL reset_data got=%h exp=0", DataOut); end
        tests++; if (DropCnt !== 8'h00)     begin fails++; $display("FAIL reset_drop got=%0d exp=0", DropCnt); end
        tests++; if (InReady !== 1'b0)      begin fails++; $display("FAIL reset_inready got=%b exp=0", InReady); end
        cycle(); cycle();
        rst_n = 1'b1;
        #1;
        tests++; if (InReady !== 1'b0)      begin fails++; $display("FAIL release_inready got=%b exp=0", InReady); end
        cycle();
        tests++; if (InReady !== 1'b1)      begin fails++; $display("FAIL post_release_inready got=%b exp=1", InReady); end
    endtask

    task automatic test_single();
        Order = 3'd3; DataIn = 32'hDEADBEEF; InValid = 1'b1; OutReady = 7'h7F;
        cycle();
        InValid = 1'b0;
        tests++; if (OutValid !== 7'b0001000) begin fails++; $display("FAIL single_valid got=%b exp=0001000", OutValid); end
        tests++; if (DataOut !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data got=%h exp=deadbeef", DataOut); end
        tests++; if (Count !== 2'd1)           begin fails++; $display("FAIL single_count1 got=%0d exp=1", Count); end
        cycle();
        tests++; if (Count !== 2'd0)           begin fails++; $display("FAIL single_count0 got=%0d exp=0", Count); end
        tests++; if (OutValid !== 7'h00)       begin fails++; $display("FAIL single_empty_valid got=%b exp=0", OutValid); end
        tests++; if (DataOut !== 32'hDEADBEEF) begin fails++; $display("FAIL single_hold got=%h exp=deadbeef", DataOut); end
    endtask

    task automatic test_fill_backpressure();
        OutReady = 7'h00;
        InValid = 1'b1; Order = 3'd0; DataIn = 32'hAAAA0001;
        cycle();
        Order = 3'd6; DataIn = 32'hBBBB0002;
        cycle();
        tests++; if (Count !== 2'd2)          begin fails++; $display("FAIL fill_count got=%0d exp=2", Count); end
        tests++; if (InReady !== 1'b0)        begin fails++; $display("FAIL fill_inready got=%b exp=0", InReady); end
        tests++; if (OutValid !== 7'b0000001) begin fails++; $display("FAIL fill_valid got=%b exp=0000001", OutValid); end
        Order = 3'd2; DataIn = 32'hCCCC0003;
        cycle();
        tests++; if (Count !== 2'd2)          begin fails++; $display("FAIL full_noaccept got=%0d exp=2", Count); end
        OutReady = 7'b0000001;
        cycle();
        InValid = 1'b0; OutReady = 7'h00;
        tests++; if (OutValid !== 7'b1000000) begin fails++; $display("FAIL bp_valid got=%b exp=1000000", OutValid); end
        tests++; if (DataOut !== 32'hBBBB0002) begin fails++; $display("FAIL bp_data got=%h exp=bbbb0002", DataOut); end
        tests++; if (InReady !== 1'b1)        begin fails++; $display("FAIL bp_inready got=%b exp=1", InReady); end
        tests++; if (Count !== 2'd1)          begin fails++; $display("FAIL bp_count got=%0d exp=1", Count); end
        OutReady = 7'h7F;
        cycle(); cycle();
        tests++; if (Count !== 2'(mq.size())) begin fails++; $display("FAIL bp_drain got=%0d exp=%0d", Count, mq.size()); end
    endtask

    task automatic test_wrong_ready();
        OutReady = 7'h00; InValid = 1'b1; Order = 3'd2; DataIn = 32'h12345678;
        cycle();
        InValid = 1'b0; OutReady = 7'b1111011;
        for (int i = 0; i < 5; i++) begin
            cycle();
            tests++;
            if (Count !== 2'd1 || DataOut !== 32'h12345678 || OutValid !== 7'b0000100) begin
                fails++;
                $display("FAIL wrong_ready cyc=%0d got cnt=%0d data=%h v=%b exp cnt=1 data=12345678 v=0000100",
                         i, Count, DataOut, OutValid);
            end
        end
        OutReady = 7'h7F;
        cycle();
        tests++; if (Count !== 2'd0) begin fails++; $display("FAIL wrong_ready_drain got=%0d exp=0", Count); end
    endtask

    task automatic test_drop();
        int bad;
        // Full FIFO: a code-7 word must not be accepted or counted.
        OutReady = 7'h00; InValid = 1'b1;
        Order = 3'd1; DataIn = 32'h1; cycle();
        Order = 3'd4; DataIn = 32'h2; cycle();
        Order = 3'd7;
        for (int i = 0; i < 3; i++) cycle();
        tests++; if (DropCnt !== 8'(mDrop) || mDrop != 0) begin fails++; $display("FAIL full_drop got=%0d exp=0", DropCnt); end
        InValid = 1'b0; OutReady = 7'h7F;
        cycle(); cycle();
        // Saturation over 300 discarded words.
        OutReady = 7'h00; InValid = 1'b1; Order = 3'd7;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            DataIn = $urandom;
            cycle();
            if (Count !== 2'd0 || OutValid !== 7'h00 || DropCnt !== 8'(mDrop)) bad++;
        end
        InValid = 1'b0;
        tests++; if (bad != 0)          begin fails++; $display("FAIL drop_stream bad_cycles=%0d exp=0", bad); end
        tests++; if (DropCnt !== 8'hFF) begin fails++; $display("FAIL drop_sat got=%0d exp=255", DropCnt); end
    endtask

    task automatic test_streaming();
        int bad;
        bad = 0;
        OutReady = 7'h7F; InValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            Order = 3'(i % 7); DataIn = 32'(i);
            cycle();
            if (Count > 2'd1 || InReady !== 1'b1 || OutValid !== expValid() || DataOut !== expData()) bad++;
            if (OutValid !== (7'b1 << (i % 7)) || DataOut !== 32'(i)) bad++;
        end
        InValid = 1'b0;
        cycle();
        tests++; if (bad != 0)        begin fails++; $display("FAIL streaming bad=%0d exp=0", bad); end
        tests++; if (Count !== 2'd0)  begin fails++; $display("FAIL streaming_end got=%0d exp=0", Count); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            InValid  = 1'($urandom_range(0, 1));
            Order    = 3'($urandom_range(0, 7));
            DataIn   = $urandom;
            OutReady = 7'($urandom_range(0, 127));
            cycle();
            if (OutValid !== expValid() || DataOut !== expData() || Count !== 2'(mq.size())
                || InReady !== mReady || DropCnt !== 8'(mDrop)) begin
                bad++;
                if (bad <= 3)
                    $display("FAIL random cyc=%0d got v=%b d=%h c=%0d r=%b dc=%0d exp v=%b d=%h c=%0d r=%b dc=%0d",
                             i, OutValid, DataOut, Count, InReady, DropCnt,
                             expValid(), expData(), mq.size(), mReady, mDrop);
            end
        end
        InValid = 1'b0; OutReady = 7'h7F;
        cycle(); cycle();
        tests++; if (bad != 0) begin fails++; $display("FAIL random_total bad=%0d exp=0", bad); end
    endtask

    task automatic test_async_reset();
        OutReady = 7'h00; InValid = 1'b1;
        Order = 3'd5; DataIn = 32'h55555555; cycle();
        Order = 3'd1; DataIn = 32'h11111111; cycle();
        InValid = 1'b0;
        tests++; if (Count !== 2'd2) begin fails++; $display("FAIL ar_precount got=%0d exp=2", Count); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (OutValid !== 7'h00 || Count !== 2'd0 || DataOut !== 32'h0 || InReady !== 1'b0 || DropCnt !== 8'h00) begin
            fails++;
            $display("FAIL async_reset got v=%b c=%0d d=%h r=%b dc=%0d exp all zero",
                     OutValid, Count, DataOut, InReady, DropCnt);
        end
        cycle();
        rst_n = 1'b1; OutReady = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++; if (OutValid !== 7'h00) begin fails++; $display("FAIL ar_stale cyc=%0d got=%b exp=0", i, OutValid); end
        end
        InValid = 1'b1; Order = 3'd4; DataIn = 32'hCAFEF00D;
        cycle();
        InValid = 1'b0;
        tests++; if (OutValid !== 7'b0010000 || DataOut !== 32'hCAFEF00D) begin
            fails++; $display("FAIL ar_newpush got v=%b d=%h exp v=0010000 d=cafef00d", OutValid, DataOut);
        end
        cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_fill_backpressure();
        test_wrong_ready();
        test_drop();
        test_streaming();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
